// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment digit multiplexer.
//   - state_t   : display FSM states (IDLE / DEAD / DRIVE)
//   - SEG_TABLE : hex nibble to logical segment pattern {g,f,e,d,c,b,a}, 1 = lit
//   - is_onehot : select validity test (exactly one bit set)
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Packed table: the leftmost entry is index 15 (F), the rightmost is index 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    // Clearing the lowest set bit leaves zero only for a single-bit value.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/seg_digit_mux_hex7seg.sv
// hex7seg: combinational hex nibble to seven-segment decoder.
//   nibble  in  4  hex value 0..F
//   seg     out 7  logical segments {g,f,e,d,c,b,a}, 1 = lit
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_digit_mux.sv
// seg_digit_mux: drives the anode/cathode pins of a multiplexed seven-segment
// display from a one-hot digit select, with dead-time blanking between digits,
// per-digit blanking, leading-zero suppression and sticky select-error flag.
//   clk      in   1          system clock
//   rst      in   1          asynchronous active-high reset
//   sel      in   DIGITS     one-hot digit select from the rotator
//   data     in   4*DIGITS   hex nibbles, digit i = data[4i+3:4i]
//   blank    in   DIGITS     per-digit force-blank mask
//   dp       in   DIGITS     per-digit decimal point request
//   lz_en    in   1          leading-zero suppression enable
//   an       out  DIGITS     anode pins
//   seg      out  7          cathode pins {g,f,e,d,c,b,a}
//   dp_n     out  1          decimal point cathode pin
//   sel_err  out  1          sticky: an invalid select was seen
module seg_digit_mux
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DEAD_CYCLES = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     sel,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic                  sel_err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // +2 keeps the counter at least one bit wide when DEAD_CYCLES is 0.
    localparam int CW = $clog2(DEAD_CYCLES + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEAD_CYCLES);

    state_t            state, state_n;
    logic [DIGITS-1:0] sel_q;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n;

    logic [IW-1:0]     sel_idx;
    logic              sel_ok;
    logic              sel_chg;
    logic [DIGITS-1:0] lz_mask;
    logic              zero_run;
    logic [3:0]        nib;
    logic [6:0]        seg_dec;
    logic              digit_off;

    logic [DIGITS-1:0] an_d, an_q;
    logic [6:0]        seg_d, seg_q;
    logic              dp_d, dp_q;
    logic              err_d, err_q;

    assign sel_ok  = is_onehot(32'(sel));
    assign sel_chg = (sel != sel_q);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it holding its old value and no latch is inferred.
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) sel_idx = IW'(i);
        end
    end

    // lz_mask[i] is set when nibbles DIGITS-1 down to i are all zero; digit 0
    // always shows, so its bit is never set.
    always_comb begin
        lz_mask  = '0;
        zero_run = lz_en;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (data[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge, independent of order.
        if (rst) begin
            state <= IDLE;
            sel_q <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            sel_q <= sel;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // Next-state logic. An invalid select overrides everything.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        if (!sel_ok) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_chg || (sel_idx != idx)) begin
                        state_n = DEAD;
                        cnt_n   = CNT_LOAD;
                    end
                end
                DEAD: begin
                    if (sel_chg) begin
                        // A newer select restarts the dead interval.
                        cnt_n = CNT_LOAD;
                    end else if (cnt == '0) begin
                        state_n = DRIVE;
                        idx_n   = sel_idx;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (sel_chg) begin
                        state_n = DEAD;
                        cnt_n   = CNT_LOAD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output logic: the registered outputs are computed from the next state so
    // the pins change on the same edge as the FSM.
    assign nib       = data[{idx_n, 2'b00} +: 4];
    assign digit_off = blank[idx_n] | lz_mask[idx_n];

    hex7seg u_hex7seg (
        .nibble (nib),
        .seg    (seg_dec)
    );

    always_comb begin
        an_d  = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        err_d = err_q | ~sel_ok;
        if (state_n == DRIVE) begin
            an_d[idx_n] = 1'b1;
            if (!digit_off) begin
                seg_d = seg_dec;
                dp_d  = dp[idx_n];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '0;
            seg_q <= '0;
            dp_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            err_q <= err_d;
        end
    end

    // Board pins are active-low when ACTIVE_LOW is set; sel_err is a status flag.
    assign an      = an_q ^ {DIGITS{ACTIVE_LOW}};
    assign seg     = seg_q ^ {7{ACTIVE_LOW}};
    assign dp_n    = dp_q ^ ACTIVE_LOW;
    assign sel_err = err_q;

endmodule

// File: tb/tb_seg_digit_mux.sv
module tb_seg_digit_mux;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel, blank, dp;
    logic [15:0] data;
    logic        lz_en;
    logic [3:0]  an, an0;
    logic [6:0]  seg, seg0;
    logic        dp_n, dp_n0, sel_err, sel_err0;

    seg_digit_mux #(.DIGITS(4), .DEAD_CYCLES(D), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .sel(sel), .data(data), .blank(blank), .dp(dp),
        .lz_en(lz_en), .an(an), .seg(seg), .dp_n(dp_n), .sel_err(sel_err)
    );

    seg_digit_mux #(.DIGITS(4), .DEAD_CYCLES(0), .ACTIVE_LOW(1'b1)) dut0 (
        .clk(clk), .rst(rst), .sel(sel), .data(data), .blank(blank), .dp(dp),
        .lz_en(lz_en), .an(an0), .seg(seg0), .dp_n(dp_n0), .sel_err(sel_err0)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b  {an,seg,dp_n,sel_err}", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    // Expected pins while digit i is driven with the current inputs.
    function automatic logic [12:0] exp_on(input int i);
        logic       lit;
        logic       allz;
        logic [6:0] s;
        logic [3:0] a;
        lit = !blank[i];
        if (lz_en && i != 0) begin
            allz = 1'b1;
            for (int j = i; j < 4; j++) if (data[4*j +: 4] != 4'h0) allz = 1'b0;
            if (allz) lit = 1'b0;
        end
        a = 4'b0001 << i;
        s = lit ? ref_seg(data[4*i +: 4]) : 7'b0;
        return {~a, ~s, ~(lit & dp[i]), exp_err};
    endfunction

    function automatic logic [12:0] exp_off();
        return {4'b1111, 7'b1111111, 1'b1, exp_err};
    endfunction

    task automatic push_off(input string tag, input int n);
        for (int k = 0; k < n; k++) sb.push_back('{tag, exp_off()});
    endtask

    task automatic push_on(input string tag, input int i, input int n);
        for (int k = 0; k < n; k++) sb.push_back('{tag, exp_on(i)});
    endtask

    // One expected entry is consumed per clock, sampled 1 time unit after the edge.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(e.tag, {an, seg, dp_n, sel_err}, e.v);
        end
    endtask

    task automatic change_sel(input logic [3:0] s, input int i, input int hold, input string tag);
        sel = s;
        push_off({tag, "_dead"}, D + 1);
        push_on(tag, i, hold);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel = 4'b0001; data = 16'h1234;
        blank = 4'b0; dp = 4'b0; lz_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {an, seg, dp_n, sel_err}, 13'b1111_1111111_1_0);
        rst = 1'b0;

        // First select after reset: 17 dark cycles, then digit 0 shows '4'.
        push_off("first_dead", D + 1);
        push_on("digit0", 0, 3);
        drain();
        dp = 4'b0001;
        push_on("dp0", 0, 2);
        drain();
        dp = 4'b0;

        change_sel(4'b0010, 1, 3, "digit1");
        change_sel(4'b0100, 2, 3, "digit2");
        change_sel(4'b1000, 3, 3, "digit3");

        // Leading-zero suppression on 0x0050.
        data = 16'h0050; lz_en = 1'b1;
        push_on("lz_d3", 3, 2);
        drain();
        change_sel(4'b0100, 2, 2, "lz_d2");
        change_sel(4'b0010, 1, 2, "lz_d1");
        change_sel(4'b0001, 0, 2, "lz_d0");
        change_sel(4'b1000, 3, 2, "lz_d3b");
        lz_en = 1'b0;
        push_on("nolz_d3", 3, 2);
        drain();
        blank = 4'b1000;
        push_on("blank_d3", 3, 2);
        drain();
        blank = 4'b0;
        data = 16'h1234;
        push_on("d3_restore", 3, 1);
        drain();

        // Select change in the middle of the dead interval.
        sel = 4'b0001;
        push_off("middead_a", 8);
        drain();
        sel = 4'b0010;
        push_off("middead_b", D + 1);
        push_on("middead_on", 1, 2);
        drain();

        // Invalid multi-hot select, then recovery.
        sel = 4'b0110;
        exp_err = 1'b1;
        push_off("invalid", 3);
        drain();
        change_sel(4'b0100, 2, 3, "recover");

        // Asynchronous reset mid-DRIVE.
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_err = 1'b0;
        #1;
        check("async_rst", {an, seg, dp_n, sel_err}, 13'b1111_1111111_1_0);

        // DEAD_CYCLES=0 instance: new anode two edges after the change.
        sel = 4'b0001;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("dead0_off_a", {an0, seg0, dp_n0, sel_err0}, exp_off());
        @(posedge clk);
        #1;
        check("dead0_on_a", {an0, seg0, dp_n0, sel_err0}, exp_on(0));
        sel = 4'b0010;
        @(posedge clk);
        #1;
        check("dead0_off_b", {an0, seg0, dp_n0, sel_err0}, exp_off());
        @(posedge clk);
        #1;
        check("dead0_on_b", {an0, seg0, dp_n0, sel_err0}, exp_on(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
